ex_hazard_ctrl: RTL and testbench
=================================

Name: ex_hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage RV32I core. Sits beside the EX stage and sequences it.
- Generates the EX forwarding-mux selects.
- Detects load-use hazards and inserts a one-cycle bubble.
- Freezes the whole pipeline while the I-side or D-side memory is outstanding.
- Flushes IF/ID and ID/EX when EX resolves a taken branch or jump.
- Keeps stall/flush performance counters.

Parameters:
- CNT_W, 32, width of the performance counters (stall_cnt, bubble_cnt, flush_cnt).

Ports:
- clk  in  1  core clock
- rst  in  1  reset, asynchronous, active-low
- id_rs1, id_rs2  in  5  source registers of the instruction in ID
- ex_rs1, ex_rs2, ex_rd  in  5  register fields of the instruction in EX
- ex_mem_read  in  1  EX instruction is a load
- ex_br_taken  in  1  EX resolved a taken branch, JAL or JALR (PC redirect)
- mem_rd  in  5  destination register in MEM
- mem_load_regfile  in  1  MEM instruction writes the regfile
- wb_rd  in  5  destination register in WB
- wb_load_regfile  in  1  WB instruction writes the regfile
- imem_read, imem_resp  in  1 each  I-side request pending / response
- dmem_req, dmem_resp  in  1 each  D-side read-or-write pending / response
- forwardA, forwardB  out  forwardingmux1_sel_t  EX operand selects
- pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load  out  1 each  pipeline register enables
- if_id_flush, id_ex_flush  out  1 each  load a NOP into the register on the next edge
- stall_cnt, bubble_cnt, flush_cnt  out  CNT_W each  saturating performance counters
- state_o  out  2  current FSM state, for debug

Behaviour:
- Reset (rst low, asynchronous):
  - state = RUN; all counters = 0.
  - All *_load = 0 and all *_flush = 0.
  - forwardA/B = id_ex.
- Forwarding: combinational, evaluated every cycle, independent of state. forwardA uses ex_rs1, forwardB uses ex_rs2; first match wins:
  1. ex_mem if mem_load_regfile && mem_rd != 0 && mem_rd == ex_rsX.
  2. mem_wb if wb_load_regfile && wb_rd != 0 && wb_rd == ex_rsX.
  3. id_ex otherwise.
  - x0 is never forwarded.
- Event definitions (combinational):
  - mem_busy = (imem_read && !imem_resp) || (dmem_req && !dmem_resp)
  - lu_haz = ex_mem_read && ex_rd != 0 && (ex_rd == id_rs1 || ex_rd == id_rs2)
- Priority: mem_busy > ex_br_taken > lu_haz.
- mem_busy:
  - All five *_load = 0; both flushes = 0.
  - Next state = MEM_WAIT.
- Taken branch (!mem_busy && ex_br_taken):
  - All loads = 1; if_id_flush = 1; id_ex_flush = 1.
  - Next state = FLUSH.
  - lu_haz is ignored: the younger instruction is squashed anyway.
- Load-use (!mem_busy && !ex_br_taken && lu_haz):
  - pc_load = 0, if_id_load = 0.
  - id_ex_load = 1 with id_ex_flush = 1 (bubble).
  - ex_mem_load = 1, mem_wb_load = 1.
  - Next state = BUBBLE.
- Otherwise: all loads = 1, no flush; next state = RUN.
- FSM states: RUN, MEM_WAIT, BUBBLE, FLUSH.
  - Transitions are exactly the next-state rules above, taken from any state.
  - The state records what the previous cycle did; outputs are Mealy on the current inputs.
- Counters, each saturating at all-ones (no wrap):
  - stall_cnt +1 every cycle mem_busy = 1.
  - bubble_cnt +1 on every cycle that enters BUBBLE.
  - flush_cnt +1 on every cycle that enters FLUSH.
- Boundary cases:
  - A branch during MEM_WAIT stays pending because EX is frozen. The flush fires in the first non-busy cycle.
  - imem and dmem stalls together count as one stall cycle per clock.
  - Reset asserted mid-stall returns to RUN with counters cleared; no partial flush is emitted.
  - A load back-to-back with a dependent instruction (BUBBLE then RUN) resolves via the mem_wb forward on the next cycle.

Decomposition:
- rv32i_types: add the hazard FSM state enum (hzstate_t).
- forwardingmux: reuse forwardingmux1_sel_t as-is.
- Sub-module: forward_unit (purely combinational operand-select logic, instantiated once per operand).
- FSM and counters live in ex_hazard_ctrl.

Test Plan:
- ALU chain: mem_rd=5, mem_load_regfile=1, ex_rs1=5, wb_rd=5, wb_load_regfile=1 -> forwardA=ex_mem. Then clear mem_load_regfile -> forwardA=mem_wb. Then ex_rs1=0 -> id_ex.
- Load-use: ex_mem_read=1, ex_rd=3, id_rs2=3 -> pc_load=0, if_id_load=0, id_ex_flush=1, next state BUBBLE, bubble_cnt=1. Next cycle hazard gone -> all loads 1.
- Cache miss: dmem_req=1, dmem_resp=0 for 4 cycles, then resp=1 -> all loads 0 for 4 cycles, stall_cnt=4, state MEM_WAIT, then RUN.
- Branch under stall: ex_br_taken=1 with imem_read=1, imem_resp=0 for 2 cycles -> no flush during the stall. Flush in cycle 3, flush_cnt=1.
- Branch plus load-use same cycle: ex_br_taken=1 and lu_haz=1 -> both flushes=1, pc_load=1, bubble_cnt unchanged.
- Reset mid-MEM_WAIT: drop rst asynchronously -> outputs go to reset values immediately; state=RUN and counters=0 after release.

Source files
------------

// File: rtl/ex_hazard_ctrl_pkg.sv
// Shared types for the EX hazard controller: operand forwarding selects and the
// hazard FSM state encoding.
package ex_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        id_ex  = 2'd0,
        ex_mem = 2'd1,
        mem_wb = 2'd2
    } forwardingmux1_sel_t;

    typedef enum logic [1:0] {
        HZ_RUN      = 2'd0,
        HZ_MEM_WAIT = 2'd1,
        HZ_BUBBLE   = 2'd2,
        HZ_FLUSH    = 2'd3
    } hzstate_t;

endpackage

// File: rtl/ex_hazard_ctrl_forward_unit.sv
// Operand-select logic for one EX source register: the youngest in-flight
// writer wins, and x0 is never forwarded.
import ex_hazard_ctrl_pkg::*;

module ex_hazard_ctrl_forward_unit (
    input  logic [4:0]          ex_rs,
    input  logic [4:0]          mem_rd,
    input  logic                mem_load_regfile,
    input  logic [4:0]          wb_rd,
    input  logic                wb_load_regfile,
    output forwardingmux1_sel_t sel
);

    always_comb begin
        sel = id_ex;
        if (mem_load_regfile && (mem_rd != 5'd0) && (mem_rd == ex_rs)) begin
            sel = ex_mem;
        end else if (wb_load_regfile && (wb_rd != 5'd0) && (wb_rd == ex_rs)) begin
            sel = mem_wb;
        end
    end

endmodule

// File: rtl/ex_hazard_ctrl.sv
// Hazard sequencer beside EX: forwarding selects, load-use bubbles, memory
// freezes, branch flushes and saturating stall/flush counters.
import ex_hazard_ctrl_pkg::*;

module ex_hazard_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [4:0]          id_rs1,
    input  logic [4:0]          id_rs2,
    input  logic [4:0]          ex_rs1,
    input  logic [4:0]          ex_rs2,
    input  logic [4:0]          ex_rd,
    input  logic                ex_mem_read,
    input  logic                ex_br_taken,
    input  logic [4:0]          mem_rd,
    input  logic                mem_load_regfile,
    input  logic [4:0]          wb_rd,
    input  logic                wb_load_regfile,
    input  logic                imem_read,
    input  logic                imem_resp,
    input  logic                dmem_req,
    input  logic                dmem_resp,
    output forwardingmux1_sel_t forwardA,
    output forwardingmux1_sel_t forwardB,
    output logic                pc_load,
    output logic                if_id_load,
    output logic                id_ex_load,
    output logic                ex_mem_load,
    output logic                mem_wb_load,
    output logic                if_id_flush,
    output logic                id_ex_flush,
    output logic [CNT_W-1:0]    stall_cnt,
    output logic [CNT_W-1:0]    bubble_cnt,
    output logic [CNT_W-1:0]    flush_cnt,
    output logic [1:0]          state_o
);

    hzstate_t            state_q, state_d;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]    bubble_cnt_q, bubble_cnt_d;
    logic [CNT_W-1:0]    flush_cnt_q, flush_cnt_d;
    forwardingmux1_sel_t fwd_a, fwd_b;
    logic                mem_busy, lu_haz;

    ex_hazard_ctrl_forward_unit u_fwd_a (
        .ex_rs            (ex_rs1),
        .mem_rd           (mem_rd),
        .mem_load_regfile (mem_load_regfile),
        .wb_rd            (wb_rd),
        .wb_load_regfile  (wb_load_regfile),
        .sel              (fwd_a)
    );

    ex_hazard_ctrl_forward_unit u_fwd_b (
        .ex_rs            (ex_rs2),
        .mem_rd           (mem_rd),
        .mem_load_regfile (mem_load_regfile),
        .wb_rd            (wb_rd),
        .wb_load_regfile  (wb_load_regfile),
        .sel              (fwd_b)
    );

    assign mem_busy = (imem_read && !imem_resp) || (dmem_req && !dmem_resp);
    assign lu_haz   = ex_mem_read && (ex_rd != 5'd0) &&
                      ((ex_rd == id_rs1) || (ex_rd == id_rs2));

    // State register and counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= HZ_RUN;
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    // Next state depends only on the current events, from any state.
    always_comb begin
        state_d = HZ_RUN;
        if (mem_busy) begin
            state_d = HZ_MEM_WAIT;
        end else if (ex_br_taken) begin
            state_d = HZ_FLUSH;
        end else if (lu_haz) begin
            state_d = HZ_BUBBLE;
        end
    end

    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        if (mem_busy && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if ((state_d == HZ_BUBBLE) && (bubble_cnt_q != '1)) begin
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end
        if ((state_d == HZ_FLUSH) && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    // Mealy outputs; reset forces every enable low so nothing moves mid-reset.
    always_comb begin
        pc_load     = 1'b0;
        if_id_load  = 1'b0;
        id_ex_load  = 1'b0;
        ex_mem_load = 1'b0;
        mem_wb_load = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        forwardA    = id_ex;
        forwardB    = id_ex;
        if (rst) begin
            forwardA = fwd_a;
            forwardB = fwd_b;
            if (!mem_busy) begin
                pc_load     = !lu_haz || ex_br_taken;
                if_id_load  = !lu_haz || ex_br_taken;
                id_ex_load  = 1'b1;
                ex_mem_load = 1'b1;
                mem_wb_load = 1'b1;
                if_id_flush = ex_br_taken;
                id_ex_flush = ex_br_taken || lu_haz;
            end
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
    assign flush_cnt  = flush_cnt_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Directed scoreboard bench for ex_hazard_ctrl: the driver queues the expected
// output image per cycle, the monitor compares it on the falling edge.
import ex_hazard_ctrl_pkg::*;

module tb_ex_hazard_ctrl;

    localparam int CNT_W = 32;
    localparam int W     = 2 + 2 + 5 + 2 + 2 + 3 * CNT_W;

    // Output image order: fwdA, fwdB, {pc,if_id,id_ex,ex_mem,mem_wb} loads,
    // {if_id,id_ex} flushes, state, stall, bubble, flush counters.
    localparam logic [1:0] F_IDEX = 2'd0, F_EXMEM = 2'd1, F_MEMWB = 2'd2;
    localparam logic [1:0] S_RUN = 2'd0, S_MW = 2'd1, S_BUB = 2'd2, S_FL = 2'd3;
    localparam logic [4:0] L_ALL = 5'b11111, L_NONE = 5'b00000, L_LU = 5'b00111;

    logic clk, rst;
    logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic ex_mem_read, ex_br_taken, mem_load_regfile, wb_load_regfile;
    logic imem_read, imem_resp, dmem_req, dmem_resp;
    forwardingmux1_sel_t forwardA, forwardB;
    logic pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load;
    logic if_id_flush, id_ex_flush;
    logic [CNT_W-1:0] stall_cnt, bubble_cnt, flush_cnt;
    logic [1:0] state_o;

    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           n_cmp, n_err;

    ex_hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .ex_br_taken(ex_br_taken),
        .mem_rd(mem_rd), .mem_load_regfile(mem_load_regfile),
        .wb_rd(wb_rd), .wb_load_regfile(wb_load_regfile),
        .imem_read(imem_read), .imem_resp(imem_resp),
        .dmem_req(dmem_req), .dmem_resp(dmem_resp),
        .forwardA(forwardA), .forwardB(forwardB),
        .pc_load(pc_load), .if_id_load(if_id_load), .id_ex_load(id_ex_load),
        .ex_mem_load(ex_mem_load), .mem_wb_load(mem_wb_load),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt),
        .state_o(state_o)
    );

    // Clock and reset.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] mk(input logic [1:0] fa, input logic [1:0] fb,
                                        input logic [4:0] ld, input logic [1:0] fl,
                                        input logic [1:0] st, input int sc,
                                        input int bc, input int fc);
        return {fa, fb, ld, fl, st, CNT_W'(sc), CNT_W'(bc), CNT_W'(fc)};
    endfunction

    // Driver tasks.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs1 = 0; id_rs2 = 0; ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0;
        mem_rd = 0; wb_rd = 0;
        ex_mem_read = 0; ex_br_taken = 0;
        mem_load_regfile = 0; wb_load_regfile = 0;
        imem_read = 0; imem_resp = 0; dmem_req = 0; dmem_resp = 0;
    endtask

    task automatic expect_out(input string nm, input logic [W-1:0] e);
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [W-1:0] e, a;
            string        nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            a  = {2'(forwardA), 2'(forwardB),
                  {pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load},
                  {if_id_flush, id_ex_flush}, state_o,
                  stall_cnt, bubble_cnt, flush_cnt};
            n_cmp++;
            if (a !== e) begin
                n_err++;
                $display("FAIL %s: got %h expected %h", nm, a, e);
            end
        end
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b0;
        clear_inputs();
        cyc();
        expect_out("reset", mk(F_IDEX, F_IDEX, L_NONE, 2'b00, S_RUN, 0, 0, 0));
        cyc();
        rst = 1'b1;
        expect_out("idle", mk(F_IDEX, F_IDEX, L_ALL, 2'b00, S_RUN, 0, 0, 0));

        // Forwarding priority.
        cyc();
        mem_rd = 5; mem_load_regfile = 1; ex_rs1 = 5; wb_rd = 5; wb_load_regfile = 1;
        expect_out("fwd_ex_mem", mk(F_EXMEM, F_IDEX, L_ALL, 2'b00, S_RUN, 0, 0, 0));
        cyc();
        mem_load_regfile = 0;
        expect_out("fwd_mem_wb", mk(F_MEMWB, F_IDEX, L_ALL, 2'b00, S_RUN, 0, 0, 0));
        cyc();
        ex_rs1 = 0; ex_rs2 = 5;
        expect_out("fwd_b_mem_wb", mk(F_IDEX, F_MEMWB, L_ALL, 2'b00, S_RUN, 0, 0, 0));
        cyc();
        mem_rd = 0; mem_load_regfile = 1; wb_rd = 0; ex_rs2 = 0;
        expect_out("fwd_x0", mk(F_IDEX, F_IDEX, L_ALL, 2'b00, S_RUN, 0, 0, 0));

        // Load-use bubble, then dependent instruction picks up mem_wb forward.
        cyc();
        clear_inputs();
        ex_mem_read = 1; ex_rd = 3; id_rs2 = 3;
        expect_out("load_use", mk(F_IDEX, F_IDEX, L_LU, 2'b01, S_RUN, 0, 0, 0));
        cyc();
        clear_inputs();
        ex_rs1 = 3; wb_rd = 3; wb_load_regfile = 1;
        expect_out("after_bubble", mk(F_MEMWB, F_IDEX, L_ALL, 2'b00, S_BUB, 0, 1, 0));

        // Four-cycle D-side miss.
        cyc();
        clear_inputs();
        dmem_req = 1;
        for (int i = 0; i < 4; i++) begin
            expect_out($sformatf("dmiss_%0d", i),
                       mk(F_IDEX, F_IDEX, L_NONE, 2'b00, (i == 0) ? S_RUN : S_MW, i, 1, 0));
            if (i < 3) cyc();
        end
        cyc();
        dmem_resp = 1;
        expect_out("dmiss_resp", mk(F_IDEX, F_IDEX, L_ALL, 2'b00, S_MW, 4, 1, 0));
        cyc();
        clear_inputs();
        expect_out("dmiss_done", mk(F_IDEX, F_IDEX, L_ALL, 2'b00, S_RUN, 4, 1, 0));

        // Taken branch held behind an I-side stall.
        cyc();
        ex_br_taken = 1; imem_read = 1;
        expect_out("br_stall_0", mk(F_IDEX, F_IDEX, L_NONE, 2'b00, S_RUN, 4, 1, 0));
        cyc();
        expect_out("br_stall_1", mk(F_IDEX, F_IDEX, L_NONE, 2'b00, S_MW, 5, 1, 0));
        cyc();
        imem_resp = 1;
        expect_out("br_flush", mk(F_IDEX, F_IDEX, L_ALL, 2'b11, S_MW, 6, 1, 0));
        cyc();
        clear_inputs();
        expect_out("br_after", mk(F_IDEX, F_IDEX, L_ALL, 2'b00, S_FL, 6, 1, 1));

        // Simultaneous I and D stalls count once.
        cyc();
        imem_read = 1; dmem_req = 1;
        expect_out("dual_stall", mk(F_IDEX, F_IDEX, L_NONE, 2'b00, S_RUN, 6, 1, 1));
        cyc();
        clear_inputs();
        expect_out("dual_after", mk(F_IDEX, F_IDEX, L_ALL, 2'b00, S_MW, 7, 1, 1));

        // Branch wins over a same-cycle load-use.
        cyc();
        ex_br_taken = 1; ex_mem_read = 1; ex_rd = 4; id_rs1 = 4;
        expect_out("br_and_lu", mk(F_IDEX, F_IDEX, L_ALL, 2'b11, S_RUN, 7, 1, 1));
        cyc();
        clear_inputs();
        expect_out("br_and_lu_after", mk(F_IDEX, F_IDEX, L_ALL, 2'b00, S_FL, 7, 1, 2));

        // Asynchronous reset in the middle of a stall.
        cyc();
        dmem_req = 1;
        expect_out("pre_rst_stall", mk(F_IDEX, F_IDEX, L_NONE, 2'b00, S_RUN, 7, 1, 2));
        cyc();
        mem_rd = 5; mem_load_regfile = 1; ex_rs1 = 5;
        expect_out("mid_stall", mk(F_EXMEM, F_IDEX, L_NONE, 2'b00, S_MW, 8, 1, 2));
        cyc();
        #1;
        rst = 1'b0;
        expect_out("async_rst", mk(F_IDEX, F_IDEX, L_NONE, 2'b00, S_RUN, 0, 0, 0));
        cyc();
        rst = 1'b1;
        clear_inputs();
        expect_out("post_rst", mk(F_IDEX, F_IDEX, L_ALL, 2'b00, S_RUN, 0, 0, 0));

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
